// File: rtl/ldpc_pkg.sv
// Shared constants and state encoding for the LDPC decoder top and its frame controller.
package ldpc_pkg;
  localparam int R      = 24;
  localparam int C      = 48;
  localparam int D      = 24;
  localparam int DATA_W = 6;
  localparam int ITER_W = 8;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ITER   = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/ldpc_frame_ctrl_if.sv
// Frame input/result output handshakes between the frame controller and its neighbours.
interface ldpc_frame_ctrl_if #(
  parameter int ITER_W = 8,
  parameter int BITS_W = 576
);
  logic              in_valid;
  logic              in_ready;
  logic [ITER_W-1:0] max_iter;
  logic              out_valid;
  logic              out_ready;
  logic [BITS_W-1:0] out_bits;
  logic              out_conv;
  logic [ITER_W-1:0] out_iters;

  modport master (
    output in_valid, max_iter, out_ready,
    input  in_ready, out_valid, out_bits, out_conv, out_iters
  );

  modport slave (
    input  in_valid, max_iter, out_ready,
    output in_ready, out_valid, out_bits, out_conv, out_iters
  );
endinterface

// File: rtl/ldpc_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module ldpc_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);
  logic [WIDTH-1:0] r_cnt;

  // Count qualifying events, sticking at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {WIDTH{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {WIDTH{1'b0}};
    end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/ldpc_frame_ctrl.sv
// Frame sequencer: loads a frame into the decoder, iterates until parity passes or the
// limit is hit, then holds the captured decisions until the result is accepted.
module ldpc_frame_ctrl
  import ldpc_pkg::*;
#(
  parameter int R      = ldpc_pkg::R,
  parameter int D      = ldpc_pkg::D,
  parameter int ITER_W = ldpc_pkg::ITER_W,
  parameter int STAT_W = ldpc_pkg::STAT_W
) (
  input  logic               clk,
  input  logic               rst,
  ldpc_frame_ctrl_if.slave   bus,
  input  logic               abort,
  output logic               dec_load,
  output logic               dec_run,
  input  logic               chk_ok,
  input  logic [R*D-1:0]     dec_bits,
  output logic               busy,
  output logic [STAT_W-1:0]  n_conv,
  output logic [STAT_W-1:0]  n_fail
);
  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_busy;
  logic [ITER_W-1:0]   r_lim;
  logic [ITER_W-1:0]   r_iter_cnt;
  logic [R*D-1:0]      r_out_bits;
  logic                r_out_conv;
  logic [ITER_W-1:0]   r_out_iters;
  logic                w_load;
  logic                w_run;
  logic                w_accept;
  logic                w_capture;
  logic                w_conv;
  logic                w_deliver;

  // Next-state and strobe decode; abort outranks every other exit from a busy state.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_run       = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_conv      = 1'b0;
    w_deliver   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = SETTLE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          w_load      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ITER;
        end
      end
      ITER: begin
        if (abort) begin
          w_load      = 1'b1;
          w_state_nxt = IDLE;
        end else if (chk_ok) begin
          w_capture   = 1'b1;
          w_conv      = 1'b1;
          w_state_nxt = DONE;
        end else if (r_iter_cnt == r_lim) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_run       = 1'b1;
        end
      end
      DONE: begin
        if (abort) begin
          w_load      = 1'b1;
          w_state_nxt = IDLE;
        end else if (bus.out_ready) begin
          w_deliver   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register with a registered busy flag that tracks the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Per-frame limit, iteration count and captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lim       <= {ITER_W{1'b0}};
      r_iter_cnt  <= {ITER_W{1'b0}};
      r_out_bits  <= {(R*D){1'b0}};
      r_out_conv  <= 1'b0;
      r_out_iters <= {ITER_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_lim      <= bus.max_iter;
        r_iter_cnt <= {ITER_W{1'b0}};
      end else if (w_run) begin
        r_iter_cnt <= r_iter_cnt + {{(ITER_W-1){1'b0}}, 1'b1};
      end else begin
        r_iter_cnt <= r_iter_cnt;
      end
      // On a limit exit iter_cnt equals lim, so one capture path serves both outcomes.
      if (w_capture) begin
        r_out_bits  <= dec_bits;
        r_out_conv  <= w_conv;
        r_out_iters <= r_iter_cnt;
      end else begin
        r_out_bits  <= r_out_bits;
        r_out_conv  <= r_out_conv;
        r_out_iters <= r_out_iters;
      end
    end
  end

  ldpc_sat_cnt #(.WIDTH(STAT_W)) u_cnt_conv (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_deliver & r_out_conv),
    .i_clr (1'b0),
    .o_cnt (n_conv)
  );

  ldpc_sat_cnt #(.WIDTH(STAT_W)) u_cnt_fail (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_deliver & ~r_out_conv),
    .i_clr (1'b0),
    .o_cnt (n_fail)
  );

  // Handshake strobes are masked during reset so no load escapes while rst is held.
  assign bus.in_ready  = (r_state == IDLE) & ~rst;
  assign dec_load      = w_load & ~rst;
  assign dec_run       = w_run;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_bits  = r_out_bits;
  assign bus.out_conv  = r_out_conv;
  assign bus.out_iters = r_out_iters;
  assign busy          = r_busy;
endmodule

// File: tb/tb_ldpc_frame_ctrl.sv
// Self-checking bench: table vectors, random frames against a frame-level model, corner sequences.
module tb_ldpc_frame_ctrl;
  localparam int BW     = 576;
  localparam int SW     = 4;
  localparam int SATMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic dec_load, dec_run, chk_ok, busy;
  logic [BW-1:0] dec_bits;
  logic [SW-1:0] n_conv, n_fail;

  ldpc_frame_ctrl_if #(.ITER_W(8), .BITS_W(BW)) bus ();

  ldpc_frame_ctrl #(.R(24), .D(24), .ITER_W(8), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .abort(abort),
    .dec_load(dec_load), .dec_run(dec_run), .chk_ok(chk_ok), .dec_bits(dec_bits),
    .busy(busy), .n_conv(n_conv), .n_fail(n_fail)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: converges once conv_at iterations have run (conv_at < 0 means never).
  int          conv_at = -1;
  int          runs = 0;
  logic [31:0] seed = 32'h0;
  logic [31:0] cur_seed = 32'h0;

  function automatic logic [BW-1:0] bits_of(input logic [31:0] s, input int n);
    logic [31:0] w;
    w = s ^ (32'(n) * 32'h9E3779B9);
    return {18{w}};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      runs <= 0;
      cur_seed <= 32'h0;
    end else if (dec_load) begin
      runs <= 0;
      cur_seed <= seed;
    end else if (dec_run) begin
      runs <= runs + 1;
    end
  end

  assign chk_ok   = (conv_at >= 0) && (runs >= conv_at);
  assign dec_bits = bits_of(cur_seed, runs);

  int n_pass = 0;
  int n_tot  = 0;
  int both_cnt = 0;
  int exp_nc = 0;
  int exp_nf = 0;

  always @(negedge clk) if (dec_load && dec_run) both_cnt++;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Run one frame from accept to delivery; d = cycles out_ready is held low in DONE.
  task automatic run_frame(input int m, input int c, input int d, input logic [31:0] s,
                           input logic exp_conv, input int exp_iters, input int exp_lat);
    int lat, nrun, bad_load, bad_hold;
    logic [BW-1:0] held;
    @(negedge clk);
    seed = s; conv_at = c; bus.max_iter = 8'(m); bus.in_valid = 1'b1;
    #1;
    chk("accept_ready", bus.in_ready, 1);
    chk("accept_load", dec_load, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1; nrun = 0;
    while (!bus.out_valid && lat < 400) begin
      if (dec_run) nrun++;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("run_pulses", nrun, exp_iters);
    chk("out_conv", bus.out_conv, exp_conv);
    chk("out_iters", bus.out_iters, exp_iters);
    chk("out_bits", bus.out_bits, bits_of(s, exp_iters));
    chk("done_not_ready", bus.in_ready, 0);
    held = bus.out_bits; bad_load = 0; bad_hold = 0;
    repeat (d) begin
      @(negedge clk);
      if (dec_load) bad_load++;
      if (bus.out_bits !== held || !bus.out_valid || bus.in_ready) bad_hold++;
    end
    if (d > 0) begin
      chk("hold_no_load", bad_load, 0);
      chk("hold_stable", bad_hold, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    if (exp_conv) exp_nc = (exp_nc < SATMAX) ? exp_nc + 1 : SATMAX;
    else          exp_nf = (exp_nf < SATMAX) ? exp_nf + 1 : SATMAX;
    #1;
    chk("n_conv", n_conv, exp_nc);
    chk("n_fail", n_fail, exp_nf);
    chk("idle_busy", busy, 0);
    chk("idle_ready", bus.in_ready, 1);
  endtask

  typedef struct {
    int m; int c; int d; logic conv; int iters; int lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int m, c, d, it;
    logic cv;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.max_iter = 8'd0;
    vecs[0] = '{10,  3,  0, 1'b1, 3, 6};
    vecs[1] = '{ 5, -1,  0, 1'b0, 5, 8};
    vecs[2] = '{ 0, -1,  0, 1'b0, 0, 3};
    vecs[3] = '{ 0,  0,  0, 1'b1, 0, 3};
    vecs[4] = '{ 4,  4,  1, 1'b1, 4, 7};
    vecs[5] = '{ 4,  5,  2, 1'b0, 4, 7};
    vecs[6] = '{ 6,  0, 20, 1'b1, 0, 3};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_bits", bus.out_bits, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_n_conv", n_conv, 0);

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].m, vecs[i].c, vecs[i].d, $urandom, vecs[i].conv, vecs[i].iters, vecs[i].lat);

    // Random frames scored by the frame-level rule: iterations = min(convergence point, limit).
    for (int i = 0; i < 25; i++) begin
      m = $urandom_range(0, 12);
      c = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 15);
      d = $urandom_range(0, 3);
      cv = (c >= 0) && (c <= m);
      it = cv ? c : m;
      run_frame(m, c, d, $urandom, cv, it, 3 + it);
    end

    // abort during IDLE is ignored
    @(negedge clk);
    abort = 1'b1;
    #1 chk("idle_abort_noload", dec_load, 0);
    @(negedge clk);
    abort = 1'b0;
    #1 chk("idle_abort_busy", busy, 0);

    // abort in ITER after two iterations
    @(negedge clk);
    conv_at = -1; seed = $urandom; bus.max_iter = 8'd10; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_iter_load", dec_load, 1);
    chk("abort_iter_norun", dec_run, 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_iter_idle", bus.in_ready, 1);
    chk("abort_iter_nvalid", bus.out_valid, 0);
    chk("abort_iter_nconv", n_conv, exp_nc);
    chk("abort_iter_nfail", n_fail, exp_nf);

    // abort together with out_ready in DONE: no count
    @(negedge clk);
    conv_at = 0; seed = $urandom; bus.max_iter = 8'd3; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_done_valid", bus.out_valid, 1);
    abort = 1'b1; bus.out_ready = 1'b1;
    #1 chk("abort_done_load", dec_load, 1);
    @(negedge clk);
    abort = 1'b0; bus.out_ready = 1'b0;
    #1;
    chk("abort_done_nvalid", bus.out_valid, 0);
    chk("abort_done_nconv", n_conv, exp_nc);
    chk("abort_done_nfail", n_fail, exp_nf);

    // drive converged frames well past the counter's ceiling
    for (int i = 0; i < SATMAX + 3; i++)
      run_frame(2, 1, 0, $urandom, 1'b1, 1, 4);
    chk("n_conv_saturated", n_conv, SATMAX);

    // reset in the middle of iterating
    @(negedge clk);
    conv_at = -1; seed = $urandom; bus.max_iter = 8'd20; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_run", dec_run, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_run", dec_run, 0);
    chk("mid_rst_load", dec_load, 0);
    chk("mid_rst_bits", bus.out_bits, 0);
    chk("mid_rst_iters", bus.out_iters, 0);
    chk("mid_rst_conv", bus.out_conv, 0);
    chk("mid_rst_nconv", n_conv, 0);
    chk("mid_rst_nfail", n_fail, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_nc = 0; exp_nf = 0;
    #1 chk("post_rst_ready", bus.in_ready, 1);

    run_frame(3, 2, 0, $urandom, 1'b1, 2, 5);
    chk("load_run_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/ldpc_frame_ctrl.md
# ldpc_frame_ctrl

Frame-level sequencer for the layered-parallel LDPC decoder array (CNU/VNU fabric plus parity checker). It accepts one frame at a time over a valid/ready handshake and pulses the decoder's load/clear. It then enables iterations until the parity check passes or a programmable iteration limit is reached, captures the hard decisions, and presents them downstream with convergence status and iteration count. It replaces free-running, self-terminating iteration control with an explicit, back-pressurable frame pipeline.

## Interface
- R, 24, block-rows of the base matrix (decision vector is R*D bits)
- D, 24, circulant size
- ITER_W, 8, width of iteration counter and limit
- STAT_W, 16, width of saturating frame statistics counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream frame (LLRs on decoder sig bus) is valid
- in_ready  out  1  controller can accept a frame
- max_iter  in  ITER_W  iteration limit; sampled at frame accept
- abort  in  1  synchronous abort of the frame in flight
- dec_load  out  1  one-cycle strobe: decoder captures LLRs and clears CNU state
- dec_run  out  1  decoder performs one iteration this cycle
- chk_ok  in  1  parity check satisfied for current dec_bits (combinational from decoder)
- dec_bits  in  R*D  current hard decisions
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_bits  out  R*D  captured decisions
- out_conv  out  1  1 = parity satisfied, 0 = limit reached
- out_iters  out  ITER_W  iterations executed for this frame
- busy  out  1  state != IDLE
- n_conv, n_fail  out  STAT_W each  saturating counts of delivered converged / failed frames

## Operation
- States: IDLE, SETTLE, ITER, DONE.
- IDLE: in_ready=1. On in_valid: dec_load=1 in the same cycle, latch max_iter into lim, iter_cnt<=0, go SETTLE.
- SETTLE: one cycle; dec_run=0; chk_ok ignored. Decoder outputs settle from the freshly loaded LLRs. Go ITER.
- ITER, evaluated in priority order:
  - chk_ok=1 → capture dec_bits, out_conv=1, out_iters=iter_cnt, go DONE.
  - Else iter_cnt==lim → capture, out_conv=0, out_iters=lim, go DONE.
  - Else dec_run=1, iter_cnt++.
- DONE: out_valid=1; out_* held stable. On out_ready: increment n_conv or n_fail (saturate at all-ones), go IDLE.
- abort=1 in SETTLE, ITER, or DONE: go IDLE next cycle, dec_load pulses (clears decoder), out_valid drops, no stats update. abort in IDLE is ignored.
- abort and out_ready in the same DONE cycle: abort wins; no stats update.
- lim=0: first ITER cycle either converges with iters=0 or fails with iters=0. No dec_run is issued.
- dec_load and dec_run are never both 1.
- Reset values: state IDLE, in_ready=1 after reset release, every other output 0 (out_bits, out_iters, counters, dec_load, dec_run, out_valid, out_conv, busy).
- Reset mid-frame: everything returns to the reset values immediately. The decoder must be reset by the same rst.

## Timing
- Frame accepted at cycle T: SETTLE at T+1, first ITER at T+2.
- Convergence detected after k iterations: out_valid at T+3+k, out_iters=k.
- Limit M reached: out_valid at T+3+M, out_iters=M, out_conv=0.
- No new frame is accepted while busy. Back-to-back throughput is one frame per 4+k cycles with out_ready held high.
- in_ready, dec_load, dec_run and out_valid are decoded from state (plus in_valid for dec_load). All other outputs are registered.

## Structure
- Package ldpc_pkg: state enum {IDLE, SETTLE, ITER, DONE}; default R, C, D, data_w, ITER_W, STAT_W constants shared with the decoder top.
- One sub-module, ldpc_sat_cnt (parameter width, inc/clr, saturating), instantiated twice for n_conv and n_fail.

## Test plan
- max_iter=10, chk_ok rises after 3 dec_run pulses → out_valid at T+6, out_conv=1, out_iters=3, n_conv=1.
- max_iter=5, chk_ok never rises → exactly 5 dec_run pulses, out_valid at T+8, out_conv=0, out_iters=5, n_fail=1.
- max_iter=0 with chk_ok=0 → no dec_run, out_iters=0, out_conv=0; repeat with chk_ok=1 → out_conv=1.
- out_ready held low 20 cycles in DONE → out_bits stable, in_ready=0, no dec_load; after release, next in_valid accepted the following cycle.
- abort in ITER after 2 iterations → dec_load pulse, IDLE next cycle, no out_valid, counters unchanged. Also abort and out_ready together in DONE → no count.
- Drive 65540 converged frames → n_conv saturates at 65535. Assert rst mid-ITER → all outputs 0 asynchronously, in_ready=1 after release.
